// File: rtl/project.sv
// 3x3 valid-convolution engine.
// Loads a 3x3 signed 8-bit kernel from weight memory, then walks records in input
// memory (header N, then N*N signed 8-bit elements), streaming each element in exactly
// once through a three-row circular line buffer. One saturated signed 16-bit result is
// written per full window, in row-major order, to consecutive output addresses.
// Optional feature: define PROJECT_RELU_EN to clamp negative results to 0x0000.
module project (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        dut_run,
    output logic        dut_busy,
    output logic [11:0] dut_sram_read_address,
    input  logic [15:0] sram_dut_read_data,
    output logic [11:0] dut_wmem_read_address,
    input  logic [15:0] wmem_dut_read_data,
    output logic [11:0] dut_sram_write_address,
    output logic [15:0] dut_sram_write_data,
    output logic        dut_sram_write_enable
);

    typedef enum logic [2:0] {StIdle, StLoadW, StReadHdr, StCompute, StDone} state_e;

    state_e state_q, state_d;

    logic        busy_q;
    logic        dv_q;          // read-data bus holds the word for last cycle's address
    logic [11:0] wmem_addr_q;
    logic [3:0]  ld_cnt_q;
    logic [11:0] rd_addr_q;     // next input-memory word to request
    logic [4:0]  n_q;
    logic [9:0]  npix_q;
    logic [9:0]  iss_cnt_q;
    logic [3:0]  row_q, col_q;
    logic [1:0]  slot_q;        // line-buffer slot holding the current row
    logic        we_q;
    logic [11:0] waddr_q, wr_ptr_q;
    logic [15:0] wdata_q;

    logic signed [7:0] kern [0:8];
    logic signed [7:0] lb [0:63];

    // FSM decode
    logic start, w_issue, w_cap, hdr_issue, hdr_cap, el_issue, el_cap;
    logic hdr_ok, row_end, last_row, win_ok, last_el;
    logic [4:0] hdr_n;
    logic [9:0] hdr_sq;

    // Window datapath
    logic [1:0]  prev1, prev2;
    logic [3:0]  cm1, cm2;
    logic signed [7:0]  win [0:8];
    logic signed [15:0] prod;
    logic signed [19:0] acc;
    logic [15:0] sat, result;
    logic        unused_wmem_hi;

    assign unused_wmem_hi = ^wmem_dut_read_data[15:8];

    assign hdr_ok   = (sram_dut_read_data >= 16'd3) && (sram_dut_read_data <= 16'd16);
    assign hdr_n    = sram_dut_read_data[4:0];
    assign hdr_sq   = {5'd0, hdr_n} * {5'd0, hdr_n};
    assign row_end  = ({1'b0, col_q} == n_q - 5'd1);
    assign last_row = ({1'b0, row_q} == n_q - 5'd1);
    assign win_ok   = el_cap && (row_q >= 4'd2) && (col_q >= 4'd2);
    assign last_el  = el_cap && row_end && last_row;

    // State register
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) state_q <= StIdle;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (start) state_d = StLoadW;
            StLoadW:   if (w_cap && ld_cnt_q == 4'd8) state_d = StReadHdr;
            StReadHdr: if (hdr_cap) state_d = hdr_ok ? StCompute : StDone;
            StCompute: if (last_el) state_d = StReadHdr;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // FSM outputs: per-state read issue and capture strobes
    always_comb begin
        start     = 1'b0;
        w_issue   = 1'b0;
        w_cap     = 1'b0;
        hdr_issue = 1'b0;
        hdr_cap   = 1'b0;
        el_issue  = 1'b0;
        el_cap    = 1'b0;
        unique case (state_q)
            StIdle:    start = dut_run;
            StLoadW: begin
                w_issue = (wmem_addr_q < 12'd9);
                w_cap   = dv_q;
            end
            StReadHdr: begin
                hdr_issue = !dv_q;
                hdr_cap   = dv_q;
            end
            // Issues N*N elements plus the next header, so the header is already
            // on the bus when the record finishes.
            StCompute: begin
                el_issue = (iss_cnt_q <= npix_q);
                el_cap   = dv_q;
            end
            default: ;
        endcase
    end

    // Gather the 3x3 window: two rows from the line buffer, current row plus live element
    always_comb begin
        prev1  = (slot_q == 2'd0) ? 2'd2 : slot_q - 2'd1;
        prev2  = (prev1 == 2'd0) ? 2'd2 : prev1 - 2'd1;
        cm1    = col_q - 4'd1;
        cm2    = col_q - 4'd2;
        win[0] = lb[{prev2, cm2}];
        win[1] = lb[{prev2, cm1}];
        win[2] = lb[{prev2, col_q}];
        win[3] = lb[{prev1, cm2}];
        win[4] = lb[{prev1, cm1}];
        win[5] = lb[{prev1, col_q}];
        win[6] = lb[{slot_q, cm2}];
        win[7] = lb[{slot_q, cm1}];
        win[8] = sram_dut_read_data[7:0];
    end

    // Nine signed products, accumulate, saturate to signed 16-bit
    always_comb begin
        acc  = '0;
        prod = '0;
        for (int i = 0; i < 9; i++) begin
            prod = kern[i] * win[i];
            acc  = acc + {{4{prod[15]}}, prod};
        end
        if (acc > 20'sd32767)       sat = 16'h7FFF;
        else if (acc < -20'sd32768) sat = 16'h8000;
        else                        sat = acc[15:0];
`ifdef PROJECT_RELU_EN
        result = sat[15] ? 16'h0000 : sat;
`else
        result = sat;
`endif
    end

    // Kernel and line-buffer storage; contents are don't-care until loaded
    always_ff @(posedge clk) begin
        if (w_cap)  kern[ld_cnt_q] <= wmem_dut_read_data[7:0];
        if (el_cap) lb[{slot_q, col_q}] <= sram_dut_read_data[7:0];
    end

    // Control counters, addresses and the registered write port
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            busy_q      <= 1'b0;
            dv_q        <= 1'b0;
            wmem_addr_q <= '0;
            ld_cnt_q    <= '0;
            rd_addr_q   <= '0;
            n_q         <= '0;
            npix_q      <= '0;
            iss_cnt_q   <= '0;
            row_q       <= '0;
            col_q       <= '0;
            slot_q      <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wr_ptr_q    <= '0;
            wdata_q     <= '0;
        end else begin
            dv_q <= w_issue | hdr_issue | el_issue;
            if (start) begin
                busy_q      <= 1'b1;
                wmem_addr_q <= '0;
                ld_cnt_q    <= '0;
                rd_addr_q   <= '0;
                wr_ptr_q    <= '0;
            end
            if (w_issue) wmem_addr_q <= wmem_addr_q + 12'd1;
            if (w_cap)   ld_cnt_q <= ld_cnt_q + 4'd1;
            if (hdr_issue || el_issue) rd_addr_q <= rd_addr_q + 12'd1;
            if (hdr_cap) begin
                n_q       <= hdr_n;
                npix_q    <= hdr_sq;
                iss_cnt_q <= '0;
                row_q     <= '0;
                col_q     <= '0;
                slot_q    <= '0;
                if (!hdr_ok) busy_q <= 1'b0;
            end
            if (el_issue) iss_cnt_q <= iss_cnt_q + 10'd1;
            if (el_cap) begin
                if (row_end) begin
                    col_q  <= '0;
                    row_q  <= row_q + 4'd1;
                    slot_q <= (slot_q == 2'd2) ? 2'd0 : slot_q + 2'd1;
                end else begin
                    col_q <= col_q + 4'd1;
                end
            end
            we_q <= win_ok;
            if (win_ok) begin
                waddr_q  <= wr_ptr_q;
                wdata_q  <= result;
                wr_ptr_q <= wr_ptr_q + 12'd1;
            end
        end
    end

    assign dut_busy               = busy_q;
    assign dut_sram_read_address  = rd_addr_q;
    assign dut_wmem_read_address  = wmem_addr_q;
    assign dut_sram_write_address = waddr_q;
    assign dut_sram_write_data    = wdata_q;
    assign dut_sram_write_enable  = we_q;

endmodule

// File: tb/tb_project.sv
// Bench for the 3x3 convolution engine: table-driven uniform-data vectors, random
// records checked against an arithmetic reference model, and reset-abort sequences.
module tb_project;

    logic        clk = 1'b0;
    logic        reset_b;
    logic        dut_run;
    logic        dut_busy;
    logic [11:0] dut_sram_read_address;
    logic [15:0] sram_dut_read_data;
    logic [11:0] dut_wmem_read_address;
    logic [15:0] wmem_dut_read_data;
    logic [11:0] dut_sram_write_address;
    logic [15:0] dut_sram_write_data;
    logic        dut_sram_write_enable;

    always #5 clk = ~clk;

    project dut (
        .clk                    (clk),
        .reset_b                (reset_b),
        .dut_run                (dut_run),
        .dut_busy               (dut_busy),
        .dut_sram_read_address  (dut_sram_read_address),
        .sram_dut_read_data     (sram_dut_read_data),
        .dut_wmem_read_address  (dut_wmem_read_address),
        .wmem_dut_read_data     (wmem_dut_read_data),
        .dut_sram_write_address (dut_sram_write_address),
        .dut_sram_write_data    (dut_sram_write_data),
        .dut_sram_write_enable  (dut_sram_write_enable)
    );

    logic [15:0] sram [0:4095];
    logic [15:0] wmem [0:4095];

    // Synchronous-read memories
    always @(posedge clk) begin
        sram_dut_read_data <= sram[dut_sram_read_address];
        wmem_dut_read_data <= wmem[dut_wmem_read_address];
    end

`ifdef PROJECT_RELU_EN
    localparam logic [15:0] NegNine = 16'h0000;
    localparam logic [15:0] NegSat  = 16'h0000;
    localparam logic [15:0] Neg36   = 16'h0000;
`else
    localparam logic [15:0] NegNine = 16'hFFF7;
    localparam logic [15:0] NegSat  = 16'h8000;
    localparam logic [15:0] Neg36   = 16'hFFDC;
`endif

    typedef struct {
        string       name;
        logic [7:0]  kval;
        logic [7:0]  eval;
        int          n;
        logic [15:0] exp_data;
    } vec_t;

    vec_t        vecs [6];
    logic [15:0] exp_q [$];
    logic [15:0] terms [5];
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic [7:0] k, input logic [7:0] e,
                                input int n, input logic [15:0] d);
        vec_t v;
        v.name = name; v.kval = k; v.eval = e; v.n = n; v.exp_data = d;
        return v;
    endfunction

    function automatic int s8(input logic [15:0] w);
        logic signed [7:0] b;
        b = w[7:0];
        return int'(b);
    endfunction

    // Reference: walk records as the memory image describes them, plain integer math
    task automatic model();
        int p, n, acc;
        exp_q.delete();
        p = 0;
        while (p < 4000) begin
            n = int'(sram[p]);
            if (n < 3 || n > 16) break;
            for (int i = 0; i < n - 2; i++) begin
                for (int j = 0; j < n - 2; j++) begin
                    acc = 0;
                    for (int ki = 0; ki < 3; ki++)
                        for (int kj = 0; kj < 3; kj++)
                            acc += s8(wmem[ki * 3 + kj]) * s8(sram[p + 1 + (i + ki) * n + j + kj]);
                    if (acc > 32767) acc = 32767;
                    if (acc < -32768) acc = -32768;
`ifdef PROJECT_RELU_EN
                    if (acc < 0) acc = 0;
`endif
                    exp_q.push_back(acc[15:0]);
                end
            end
            p += 1 + n * n;
        end
    endtask

    task automatic fill_uniform(input logic [7:0] k, input logic [7:0] e, input int n);
        for (int i = 0; i < 9; i++) wmem[i] = {8'($urandom), k};
        sram[0] = 16'(n);
        for (int i = 0; i < n * n; i++) sram[1 + i] = {8'($urandom), e};
        sram[1 + n * n] = 16'hFFFF;
    endtask

    task automatic fill_random(input int nrec, input int nfix, input logic [15:0] term);
        int p, n;
        for (int i = 0; i < 9; i++) wmem[i] = 16'($urandom);
        p = 0;
        for (int r = 0; r < nrec; r++) begin
            n = (nfix != 0) ? nfix : int'($urandom_range(3, 16));
            sram[p] = 16'(n);
            for (int i = 0; i < n * n; i++) sram[p + 1 + i] = 16'($urandom);
            p += 1 + n * n;
        end
        sram[p] = term;
    endtask

    // Pulse run, check every write against exp_q, then busy-fall timing
    task automatic run_job(input string name, input bit poke);
        int nwr, last_wr, cyc;
        bit fell;
        @(negedge clk) dut_run = 1'b1;
        @(negedge clk) dut_run = 1'b0;
        check({name, " busy_rise"}, 32'(dut_busy), 32'd1);
        nwr = 0; last_wr = -1; fell = 1'b0;
        for (cyc = 0; cyc < 6000; cyc++) begin
            if (dut_sram_write_enable) begin
                if (nwr < exp_q.size()) begin
                    check({name, " waddr"}, 32'(dut_sram_write_address), 32'(nwr));
                    check({name, " wdata"}, 32'(dut_sram_write_data), 32'(exp_q[nwr]));
                end
                nwr++;
                last_wr = cyc;
            end
            if (!dut_busy) begin
                fell = 1'b1;
                break;
            end
            dut_run = (poke && cyc == 30);
            @(negedge clk);
        end
        dut_run = 1'b0;
        check({name, " finished_in_budget"}, 32'(fell), 32'd1);
        check({name, " write_count"}, 32'(nwr), 32'(exp_q.size()));
        if (exp_q.size() > 0) check({name, " busy_fall_cycle"}, 32'(cyc), 32'(last_wr + 1));
        repeat (3) @(negedge clk);
        check({name, " quiet_after"}, {30'd0, dut_busy, dut_sram_write_enable}, 32'd0);
    endtask

    initial begin
        int seen, stray, nout;
        terms[0] = 16'hFFFF; terms[1] = 16'h0000; terms[2] = 16'h0002;
        terms[3] = 16'h0011; terms[4] = 16'h8003;
        vecs[0] = mk("ones",     8'h01, 8'h01, 4,  16'h0009);
        vecs[1] = mk("pos_sat",  8'h7F, 8'h7F, 3,  16'h7FFF);
        vecs[2] = mk("neg_nine", 8'hFF, 8'h01, 3,  NegNine);
        vecs[3] = mk("neg_sat",  8'h80, 8'h7F, 3,  NegSat);
        vecs[4] = mk("neg_36",   8'h02, 8'hFE, 5,  Neg36);
        vecs[5] = mk("n16",      8'h03, 8'h05, 16, 16'h0087);
        for (int i = 0; i < 4096; i++) begin
            sram[i] = 16'hFFFF;
            wmem[i] = 16'h0000;
        end
        reset_b = 1'b0;
        dut_run = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", 32'(dut_busy), 32'd0);
        check("reset we", 32'(dut_sram_write_enable), 32'd0);
        check("reset raddr", 32'(dut_sram_read_address), 32'd0);
        check("reset waddr_w", 32'(dut_wmem_read_address), 32'd0);
        check("reset wr_addr", 32'(dut_sram_write_address), 32'd0);
        check("reset wdata", 32'(dut_sram_write_data), 32'd0);
        reset_b = 1'b1;
        repeat (2) @(negedge clk);
        check("idle busy", 32'(dut_busy), 32'd0);

        // Uniform-data vectors: every output equals the table value
        foreach (vecs[v]) begin
            fill_uniform(vecs[v].kval, vecs[v].eval, vecs[v].n);
            exp_q.delete();
            nout = (vecs[v].n - 2) * (vecs[v].n - 2);
            for (int i = 0; i < nout; i++) exp_q.push_back(vecs[v].exp_data);
            run_job(vecs[v].name, 1'b0);
        end

        // Two records back to back, then a second run must restart at address 0
        fill_random(1, 3, 16'hFFFF);
        sram[10] = 16'd4;
        for (int i = 0; i < 16; i++) sram[11 + i] = 16'($urandom);
        sram[27] = 16'hFFFF;
        model();
        check("two_rec expected size", 32'(exp_q.size()), 32'd5);
        run_job("two_rec", 1'b1);
        run_job("two_rec_rerun", 1'b0);

        // Zero records
        sram[0] = 16'hFFFF;
        model();
        run_job("zero_ffff", 1'b0);
        sram[0] = 16'h0002;
        model();
        run_job("zero_hdr2", 1'b0);

        // Random records and terminators
        for (int t = 0; t < 8; t++) begin
            fill_random(int'($urandom_range(0, 3)), 0, terms[$urandom_range(0, 4)]);
            model();
            run_job("random", t[0]);
        end

        // Reset in the middle of computing
        fill_random(1, 16, 16'hFFFF);
        @(negedge clk) dut_run = 1'b1;
        @(negedge clk) dut_run = 1'b0;
        seen = 0;
        for (int c = 0; c < 2000 && seen == 0; c++) begin
            @(negedge clk);
            if (dut_sram_write_enable) seen = 1;
        end
        check("abort writes_started", 32'(seen), 32'd1);
        repeat (3) @(negedge clk);
        reset_b = 1'b0;
        #1;
        check("abort we", 32'(dut_sram_write_enable), 32'd0);
        check("abort busy", 32'(dut_busy), 32'd0);
        check("abort raddr", 32'(dut_sram_read_address), 32'd0);
        check("abort wr_addr", 32'(dut_sram_write_address), 32'd0);
        repeat (2) @(negedge clk);
        reset_b = 1'b1;
        stray = 0;
        repeat (30) begin
            @(negedge clk);
            if (dut_sram_write_enable || dut_busy) stray++;
        end
        check("abort no_activity", 32'(stray), 32'd0);
        fill_random(2, 0, 16'hFFFF);
        model();
        run_job("after_abort", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
